pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/md_stall_counter.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// the hard-wired zero register index and the default mult/div latency.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         MD_CYCLES_DEF = 4;

endpackage

// File: rtl/md_stall_counter.sv
// Down-counter tracking the remaining MD_BUSY cycles of a multiply/divide;
// loaded on acceptance of the operation, decremented while busy.
module md_stall_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    // The accepting RUN cycle is the first stall cycle, so the busy phase
    // lasts MD_CYCLES-1 cycles: counting MD_CYCLES-2 down to 0 inclusive.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// multi-cycle mult/div stall, with a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        md_start,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        busy,
    output logic [31:0] stall_count
);

    state_e      state_q, state_d;
    logic        load_use;
    logic        md_load, md_dec, md_zero;
    logic [31:0] stall_count_q, stall_count_d;

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    md_stall_counter #(
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_md_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (md_load),
        .dec_i  (md_dec),
        .zero_o (md_zero)
    );

    // Outputs are Mealy; reset forces the free-running defaults.
    always_comb begin
        state_d      = state_q;
        md_load      = 1'b0;
        md_dec       = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (reset) begin
            case (state_q)
                RUN: begin
                    if (md_start) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_en    = 1'b0;
                        ex_mem_flush = 1'b1;
                        md_load      = 1'b1;
                        state_d      = MD_BUSY;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (branch_taken) begin
                        if_id_flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    ex_mem_flush = 1'b1;
                    md_dec       = !md_zero;
                    if (md_zero) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign busy        = (state_q == MD_BUSY);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a behavioural model pushes
// expected outputs per cycle, compared against the DUT half a cycle later.
module tb_pipeline_hazard_ctrl;

    localparam int MD = 4;

    typedef struct packed {
        logic [7:0]  ctl;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        ex_mem_read = 1'b0, branch_taken = 1'b0, md_start = 1'b0;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, busy;
    logic [31:0] stall_count;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          md_left  = 0;
    logic [31:0] m_stall  = '0;

    pipeline_hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .busy         (busy),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, predict, compare
    // on the rising edge, and advance the model across the next falling edge.
    task automatic step(input string tag, input logic r, input logic md, input logic mr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input logic br);
        exp_t e;
        exp_t got;
        logic lu;
        @(negedge clk);
        #1;
        reset = r; md_start = md; ex_mem_read = mr; ex_rt = ert;
        id_rs = rs; id_rt = rt; branch_taken = br;
        lu = mr && (ert != 5'd0) && ((ert == rs) || (ert == rt));
        if (!r) begin
            md_left = 0;
            m_stall = '0;
            e.ctl   = 8'b11111_000;
            e.busy  = 1'b0;
            e.cnt   = '0;
        end else begin
            e.busy = (md_left > 0);
            if ((md_left > 0) || md) e.ctl = 8'b00001_001;
            else if (lu)             e.ctl = 8'b00111_010;
            else if (br)             e.ctl = 8'b11111_100;
            else                     e.ctl = 8'b11111_000;
            e.cnt = m_stall;
            if (!e.ctl[7] && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
            if (md_left > 0) md_left--;
            else if (md)     md_left = MD - 1;
        end
        sb_q.push_back(e);
        @(posedge clk);
        got.ctl  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, ex_mem_flush};
        got.busy = busy;
        got.cnt  = stall_count;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_ctl"},  32'(got.ctl),  32'(e.ctl));
            chk({tag, "_busy"}, 32'(got.busy), 32'(e.busy));
            chk({tag, "_cnt"},  got.cnt,       e.cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset holds outputs at defaults even with every hazard asserted.
        step("rst0", 0, 1, 1, 5'd8, 5'd8, 5'd8, 1);
        step("rst1", 0, 0, 1, 5'd3, 5'd3, 5'd0, 1);
        step("run0", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("run1", 1, 0, 0, 5'd1, 5'd2, 5'd3, 0);

        step("lu_rs", 1, 0, 1, 5'd8, 5'd8, 5'd1, 0);
        step("lu_rs_after", 1, 0, 0, 5'd8, 5'd8, 5'd1, 0);
        step("lu_rt", 1, 0, 1, 5'd12, 5'd1, 5'd12, 0);
        step("nomatch", 1, 0, 1, 5'd9, 5'd1, 5'd2, 0);
        step("noload", 1, 0, 0, 5'd9, 5'd9, 5'd9, 0);
        step("zero_reg", 1, 0, 1, 5'd0, 5'd0, 5'd0, 0);
        step("br", 1, 0, 0, 5'd0, 5'd4, 5'd5, 1);
        step("br_after", 1, 0, 0, 5'd0, 5'd4, 5'd5, 0);
        step("br_lu", 1, 0, 1, 5'd7, 5'd7, 5'd0, 1);
        step("br_zero", 1, 0, 1, 5'd0, 5'd0, 5'd0, 1);

        // Mult/div with hazards asserted during busy to show they are ignored.
        step("md0", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step("md1", 1, 0, 1, 5'd6, 5'd6, 5'd6, 1);
        step("md2", 1, 0, 0, 5'd0, 5'd0, 5'd0, 1);
        step("md3", 1, 0, 1, 5'd3, 5'd0, 5'd3, 0);
        step("md_done", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);

        // Back-to-back: new op accepted on the first RUN cycle after exit.
        step("b2b0", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < MD - 1; i++) step("b2b_busy", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("b2b_new", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < MD - 1; i++) step("b2b_busy2", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("b2b_done", 1, 0, 1, 5'd2, 5'd2, 5'd0, 0);

        // Reset in the second busy cycle aborts the operation.
        step("abort_md", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step("abort_b1", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("abort_rst", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("abort_rst2", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step("abort_run", 1, 0, 0, 5'd0, 5'd0, 5'd0, 1);
        step("abort_run2", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);

        // Saturation: preload the counter just below its maximum.
        @(negedge clk);
        #2;
        force dut.stall_count_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_count_q;
        m_stall = 32'hFFFF_FFFD;
        step("sat_md", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < MD - 1; i++) step("sat_busy", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("sat_lu", 1, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        step("sat_end", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);

        // Reset and random traffic.
        step("rst_r", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < 60; i++) begin
            step("rand", 1, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
